// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and helpers for the pipelined adder-subtractor
package addsub_pkg;
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic valid;
        op_e  sub;
        logic carry;
    } stage_ctl_t;

    function automatic int stages_f(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction
endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: N-bit ripple-carry adder built from full-adder cells
module rca_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);
    logic [N:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = ((a[i] ^ b[i]) & c[i]) | (a[i] & b[i]);
    end
    assign cout     = c[N];
    assign c_msb_in = c[N-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: chunked, pipelined adder-subtractor with valid/ready handshake
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CHUNK  = 4,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int STAGES = stages_f(WIDTH, CHUNK);
    logic              advance;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic              ovf_nx;
    logic              ovf_q;
    logic [STAGES-1:0] co;
    op_e               op_in;
    stage_ctl_t        ctl [STAGES];
    // A stalled output freezes every stage; bubbles are kept, not collapsed
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign op_in     = in_sub ? OP_SUB : OP_ADD;
    assign b_eff     = in_sub ? ~in_b : in_b;
    assign cin_eff   = in_sub ? ~in_cin : in_cin;
    assign out_valid = ctl[STAGES-1].valid;
    assign out_cout  = ctl[STAGES-1].carry ^ (ctl[STAGES-1].sub == OP_SUB);
    assign out_ovf   = SIGNED ? ovf_q : out_cout;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < STAGES; i++) ctl[i] <= '0;
            ovf_q <= 1'b0;
        end else if (advance) begin
            ctl[0] <= '{valid: in_valid, sub: op_in, carry: co[0]};
            for (int i = 1; i < STAGES; i++)
                ctl[i] <= '{valid: ctl[i-1].valid, sub: ctl[i-1].sub, carry: co[i]};
            ovf_q <= ovf_nx;
        end
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int N  = (WIDTH - LO < CHUNK) ? WIDTH - LO : CHUNK;
        localparam int D  = STAGES - k;
        logic [N-1:0] a_d, b_d, s_ch;
        logic         c_in, cm;
        logic [N-1:0] s_q [D];
        if (k == 0) begin : g_head
            assign a_d  = in_a[LO +: N];
            assign b_d  = b_eff[LO +: N];
            assign c_in = cin_eff;
        end else begin : g_skew
            // Operand chunk k waits k cycles for the carry to reach it
            logic [N-1:0] a_q [k];
            logic [N-1:0] b_q [k];
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    for (int i = 0; i < k; i++) begin
                        a_q[i] <= '0;
                        b_q[i] <= '0;
                    end
                end else if (advance) begin
                    a_q[0] <= in_a[LO +: N];
                    b_q[0] <= b_eff[LO +: N];
                    for (int i = 1; i < k; i++) begin
                        a_q[i] <= a_q[i-1];
                        b_q[i] <= b_q[i-1];
                    end
                end
            assign a_d  = a_q[k-1];
            assign b_d  = b_q[k-1];
            assign c_in = ctl[k-1].carry;
        end
        rca_chunk #(.N(N)) u_rca (
            .a        (a_d),
            .b        (b_d),
            .cin      (c_in),
            .s        (s_ch),
            .cout     (co[k]),
            .c_msb_in (cm)
        );
        // Result chunk k is held until the top chunk catches up
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                for (int i = 0; i < D; i++) s_q[i] <= '0;
            end else if (advance) begin
                s_q[0] <= s_ch;
                for (int i = 1; i < D; i++) s_q[i] <= s_q[i-1];
            end
        assign out_sum[LO +: N] = s_q[D-1];
        if (k == STAGES - 1) begin : g_top
            assign ovf_nx = co[k] ^ cm;
        end else begin : g_low
            logic cm_unused;
            assign cm_unused = cm;
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: randomized scoreboard bench for pipelined_addsub and parameter variants
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, in_sub = 1'b0, in_cin = 1'b0, out_ready = 1'b1;
    logic [7:0] in_a = '0, in_b = '0;
    logic       in_ready, out_valid, out_cout, out_ovf;
    logic [7:0] out_sum;

    logic        sv = 1'b0, ssub = 1'b0, scin = 1'b0;
    logic [15:0] sa = '0, sb = '0;
    logic        r1, v1, c1, o1, r2, v2, c2, o2, r3, v3, c3, o3;
    logic [12:0] s1;
    logic [7:0]  s2, s3;

    pipelined_addsub #(.WIDTH(8), .CHUNK(4), .SIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_sub(in_sub), .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf));
    pipelined_addsub #(.WIDTH(13), .CHUNK(5), .SIGNED(1'b1)) d13 (
        .clk(clk), .rst(rst), .in_valid(sv), .in_ready(r1), .in_a(sa[12:0]), .in_b(sb[12:0]),
        .in_sub(ssub), .in_cin(scin), .out_valid(v1), .out_ready(1'b1),
        .out_sum(s1), .out_cout(c1), .out_ovf(o1));
    pipelined_addsub #(.WIDTH(8), .CHUNK(8), .SIGNED(1'b1)) d8 (
        .clk(clk), .rst(rst), .in_valid(sv), .in_ready(r2), .in_a(sa[7:0]), .in_b(sb[7:0]),
        .in_sub(ssub), .in_cin(scin), .out_valid(v2), .out_ready(1'b1),
        .out_sum(s2), .out_cout(c2), .out_ovf(o2));
    pipelined_addsub #(.WIDTH(8), .CHUNK(4), .SIGNED(1'b0)) du (
        .clk(clk), .rst(rst), .in_valid(sv), .in_ready(r3), .in_a(sa[7:0]), .in_b(sb[7:0]),
        .in_sub(ssub), .in_cin(scin), .out_valid(v3), .out_ready(1'b1),
        .out_sum(s3), .out_cout(c3), .out_ovf(o3));

    int          n_checks = 0, n_fail = 0;
    logic [17:0] exp_q [$];
    logic [17:0] q1 [$], q2 [$], q3 [$];
    logic        popped, accepted;
    logic [9:0]  got;

    // Reference: {ovf, cout, sum} from integer arithmetic on the operand values
    function automatic logic [17:0] model(input int w, input bit sgn, input logic [15:0] a,
                                          input logic [15:0] b, input bit sub, input bit cin);
        longint m, ua, ub, ci, r, sa_v, sb_v, sr, half;
        logic   cout, ovf;
        half = longint'(1) << (w - 1);
        m    = (longint'(1) << w) - 1;
        ua   = a;
        ub   = b;
        ua   = ua & m;
        ub   = ub & m;
        ci   = cin;
        r    = sub ? ua - ub - ci : ua + ub + ci;
        sa_v = (ua >= half) ? ua - (m + 1) : ua;
        sb_v = (ub >= half) ? ub - (m + 1) : ub;
        sr   = sub ? sa_v - sb_v - ci : sa_v + sb_v + ci;
        cout = sub ? (r < 0) : (r > m);
        ovf  = sgn ? ((sr < -half) || (sr >= half)) : cout;
        return {ovf, cout, 16'(r & m)};
    endfunction

    task automatic tick(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input logic cin, input logic rdy);
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_sub = sub; in_cin = cin; out_ready = rdy;
        #1;
        popped   = out_valid && out_ready;
        got      = {out_ovf, out_cout, out_sum};
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(model(8, 1'b1, {8'h0, a}, {8'h0, b}, sub, cin));
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic sub,
                           input logic cin, output int lat, output logic [9:0] r);
        exp_q.delete();
        lat = 0;
        r   = 'x;
        tick(1'b1, a, b, sub, cin, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1);
            if (popped) begin
                lat = i;
                r   = got;
                break;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++;
        if ({out_valid, out_cout, out_ovf, out_sum} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {out_valid, out_cout, out_ovf, out_sum});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_checks++;
        if ({v1, v2, v3} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_variants_valid: got %b want 000", {v1, v2, v3});
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [9:0] r;
        run_one(8'h7F, 8'h01, 1'b0, 1'b0, lat, r);
        n_checks++;
        if (r !== {1'b1, 1'b0, 8'h80}) begin
            n_fail++;
            $display("FAIL basic_add: got %h want %h", r, {1'b1, 1'b0, 8'h80});
        end
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 2", lat);
        end
    endtask

    task automatic test_borrow();
        int lat;
        logic [9:0] r;
        run_one(8'h10, 8'h20, 1'b1, 1'b0, lat, r);
        n_checks++;
        if (r !== {1'b0, 1'b1, 8'hF0}) begin
            n_fail++;
            $display("FAIL borrow_sub: got %h want %h", r, {1'b0, 1'b1, 8'hF0});
        end
        run_one(8'h80, 8'h01, 1'b1, 1'b0, lat, r);
        n_checks++;
        if (r !== {1'b1, 1'b0, 8'h7F}) begin
            n_fail++;
            $display("FAIL sub_overflow: got %h want %h", r, {1'b1, 1'b0, 8'h7F});
        end
        run_one(8'hFF, 8'h01, 1'b0, 1'b1, lat, r);
        n_checks++;
        if (r !== {1'b0, 1'b1, 8'h01}) begin
            n_fail++;
            $display("FAIL carry_chain: got %h want %h", r, {1'b0, 1'b1, 8'h01});
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        int pops = 0, last = -1, gaps = 0;
        logic [7:0] a, b;
        logic sub, cin;
        exp_q.delete();
        for (int i = 0; i < 108; i++) begin
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            if (i == 50) begin a = 8'hFF; b = 8'h01; sub = 1'b0; cin = 1'b1; end
            tick(i < 100, a, b, sub, cin, 1'b1);
            if (popped) begin
                n_checks++;
                if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
                if (got !== {e[17:16], e[7:0]}) begin
                    n_fail++;
                    $display("FAIL stream_beat%0d: got %h want %h", pops, got, {e[17:16], e[7:0]});
                end
                if (last >= 0 && i != last + 1) gaps++;
                last = i;
                pops++;
            end
        end
        n_checks++;
        if (pops !== 100 || gaps !== 0) begin
            n_fail++;
            $display("FAIL stream_rate: got %0d beats %0d gaps want 100 beats 0 gaps", pops, gaps);
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] e;
        logic [9:0]  hold = '0;
        int pushes = 0, pops = 0;
        exp_q.delete();
        for (int i = 0; i < 63; i++) begin
            if (i >= 3 && i < 8)
                tick(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            else
                tick(i < 33, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                     i < 8 || i >= 33 || $urandom_range(0, 3) != 0);
            if (accepted) pushes++;
            if (i >= 3 && i < 8) begin
                n_checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_ready: got in_ready %b out_valid %b want 0 1", in_ready, out_valid);
                end
                if (i == 3) hold = got;
                else begin
                    n_checks++;
                    if (got !== hold) begin
                        n_fail++;
                        $display("FAIL stall_hold: got %h want %h", got, hold);
                    end
                end
            end
            if (popped) begin
                n_checks++;
                pops++;
                if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
                if (got !== {e[17:16], e[7:0]}) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: got %h want %h", pops, got, {e[17:16], e[7:0]});
                end
            end
        end
        n_checks++;
        if (pops !== pushes || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d out want %0d in", pops, pushes);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        logic [9:0] r;
        logic [17:0] e;
        exp_q.delete();
        for (int i = 0; i < 4; i++)
            tick(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        #2;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: got %b want 1", out_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got valid %b sum %h want 0 00", out_valid, out_sum);
        end
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        e = model(8, 1'b1, 16'h33, 16'h44, 1'b1, 1'b1);
        run_one(8'h33, 8'h44, 1'b1, 1'b1, lat, r);
        n_checks++;
        if (r !== {e[17:16], e[7:0]} || lat !== 2) begin
            n_fail++;
            $display("FAIL post_reset_first: got %h lat %0d want %h lat 2", r, lat, {e[17:16], e[7:0]});
        end
    endtask

    task automatic test_sweep();
        logic [17:0] e;
        int l1 = -1, l2 = -1, l3 = -1;
        q1.delete(); q2.delete(); q3.delete();
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            sv = (i == 0) || (i >= 5 && i < 37);
            ssub = i[1]; scin = i[0]; sa = 16'($urandom); sb = 16'($urandom);
            #1;
            if (v1) begin
                n_checks++;
                if (l1 < 0) l1 = i;
                if (q1.size() != 0) e = q1.pop_front(); else e = 'x;
                if ({o1, c1, s1} !== {e[17:16], e[12:0]}) begin
                    n_fail++;
                    $display("FAIL w13c5: got %h want %h", {o1, c1, s1}, {e[17:16], e[12:0]});
                end
            end
            if (v2) begin
                n_checks++;
                if (l2 < 0) l2 = i;
                if (q2.size() != 0) e = q2.pop_front(); else e = 'x;
                if ({o2, c2, s2} !== {e[17:16], e[7:0]}) begin
                    n_fail++;
                    $display("FAIL w8c8: got %h want %h", {o2, c2, s2}, {e[17:16], e[7:0]});
                end
            end
            if (v3) begin
                n_checks++;
                if (l3 < 0) l3 = i;
                if (q3.size() != 0) e = q3.pop_front(); else e = 'x;
                if ({o3, c3, s3} !== {e[17:16], e[7:0]} || o3 !== c3) begin
                    n_fail++;
                    $display("FAIL unsigned_ovf: got %h want %h", {o3, c3, s3}, {e[17:16], e[7:0]});
                end
            end
            if (sv) begin
                q1.push_back(model(13, 1'b1, sa, sb, ssub, scin));
                q2.push_back(model(8, 1'b1, sa, sb, ssub, scin));
                q3.push_back(model(8, 1'b0, sa, sb, ssub, scin));
            end
        end
        sv = 1'b0;
        n_checks++;
        if (l1 !== 3 || l2 !== 1 || l3 !== 2) begin
            n_fail++;
            $display("FAIL sweep_latency: got %0d %0d %0d want 3 1 2", l1, l2, l3);
        end
        n_checks++;
        if (q1.size() + q2.size() + q3.size() != 0) begin
            n_fail++;
            $display("FAIL sweep_drain: got %0d pending want 0", q1.size() + q2.size() + q3.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
